cic_decim_ctrl: RTL and testbench
=================================

// Module: cic_decim_ctrl
// PURPOSE
//  Sequencer for the CIC decimator datapath (integrator chain -> decimate-by-R -> comb chain).
//  Generates integrator and comb enable strobes, counts the decimation phase and clears the datapath on start.
//  Masks outputs until the comb delay lines hold real data, and applies ratio changes only at decimation boundaries.
//  Sits between the sample source strobe and the val_in pins of every integrator and comb stage.
// PARAMETERS
//  RW     8   width of decimation ratio R; legal R = 2 .. 2^RW-1
//  N_STG  3   number of comb stages; fill length in comb strobes
//  R_DEF  16  ratio loaded at reset
// PORTS
//  clk       in   1    system clock, single domain
//  rst       in   1    asynchronous, active-low reset
//  en        in   1    run enable; level-sensitive
//  val_in    in   1    input sample strobe, one cycle per sample
//  cfg_r     in   RW   requested decimation ratio
//  cfg_load  in   1    one-cycle strobe; capture cfg_r
//  int_clr   out  1    one-cycle synchronous clear pulse to integrators/combs (their active-high rst)
//  int_en    out  1    integrator val_in enable
//  comb_en   out  1    comb val_in enable, once per R accepted samples
//  val_out   out  1    decimated output valid
//  busy      out  1    state != IDLE
//  cfg_err   out  1    sticky illegal-ratio flag
// BEHAVIOUR
//  - rst=0 (async): state=IDLE; all outputs 0; r_act=r_pend=R_DEF; dcnt=0; fcnt=0. Mid-operation: same, immediately.
//  - All outputs are registered. Latency from a val_in sample to its int_en/comb_en is 1 cycle.
//  - FSM: IDLE(2'b00), FILL(2'b01), RUN(2'b10).
//    - IDLE -> FILL when en=1: int_clr=1 for 1 cycle; dcnt=0; fcnt=0; r_act<=r_pend.
//    - FILL/RUN -> IDLE when en=0, on the next edge: counters cleared; int_en, comb_en and val_out are 0 from that edge.
//      A val_in coincident with en=0 is dropped.
//  - In FILL/RUN, val_in=1 gives int_en=1 next cycle.
//    - If dcnt==r_act-1: comb_en=1 (same cycle as int_en) and dcnt wraps to 0; else dcnt++.
//    - Cycles with val_in=0 do not advance dcnt.
//  - FILL: fcnt counts issued comb_en pulses. The edge that drives the N_STG-th comb_en moves to RUN. fcnt saturates.
//  - RUN: val_out <= comb_en registered, so it is high the cycle after each comb_en.
//    The first val_out follows comb strobe N_STG+1, i.e. sample (N_STG+1)*R from start.
//  - cfg_load=1:
//    - if 2 <= cfg_r: r_pend<=cfg_r, cfg_err<=0.
//    - else: r_pend unchanged, cfg_err<=1 (held until the next legal load or reset).
//  - r_pend -> r_act only at a wrap (edge issuing comb_en) or at IDLE->FILL.
//    - If r_pend != r_act at a wrap in RUN: state->FILL, fcnt=0, no int_clr.
//    - A cfg_load in the same cycle as a wrap is not applied at that wrap; it takes effect at the next wrap.
//  - Width: dcnt is RW bits and never exceeds r_act-1. fcnt is ceil(log2(N_STG+1)) bits.
// STRUCTURE
//  - Shared package cic_pkg holds: state encodings IDLE/FILL/RUN, R_MIN=2, R_DEF, N_STG, and function clog2.
//    It is shared with the integrator and comb modules.
//  - Sub-module cic_dec_cnt: modulo-r_act counter with inc, clear and load-ratio inputs and a registered wrap output.
//  - FSM, fill counter and config registers stay in cic_decim_ctrl.
// TESTING (R_DEF=16, N_STG=3, RW=8)
//  1. Reset with rst=0 mid-RUN -> all outputs 0 asynchronously; after release with en=1, int_clr pulses once and r_act=16.
//  2. cfg_r=4 loaded, en=1, continuous val_in
//     -> comb_en after samples 4, 8, 12, 16...; RUN entered with the 3rd comb_en; first val_out the cycle after sample 16's comb_en.
//  3. R=4, val_in 1-of-3 cycles -> comb_en only on every 4th strobe; int_en count equals val_in count.
//  4. RUN at R=4, cfg_load cfg_r=8 at dcnt=1
//     -> next wrap at R=4, state->FILL, no val_out for 3 comb strobes, then comb_en every 8 samples.
//  5. cfg_load cfg_r=1 -> cfg_err=1, ratio unchanged; then cfg_load cfg_r=5 -> cfg_err=0.
//  6. en=0 with val_in=1 in RUN -> next cycle int_en=0, busy=0; en=1 again -> int_clr pulse, val_out masked until refill.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared types and constants for the CIC decimator.
// Used by the sequencer, integrator and comb stages.
package cic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    RUN  = 2'b10
  } state_t;

  localparam int R_MIN = 2;
  localparam int R_DEF = 16;
  localparam int N_STG = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/cic_decim_ctrl_if.sv
// Control bundle between sample source and CIC sequencer.
// master: strobe/config side; slave: sequencer.
interface cic_decim_ctrl_if #(
  parameter int RW = 8
);

  logic          en;
  logic          val_in;
  logic [RW-1:0] cfg_r;
  logic          cfg_load;
  logic          int_clr;
  logic          int_en;
  logic          comb_en;
  logic          val_out;
  logic          busy;
  logic          cfg_err;

  modport master (
    output en, val_in, cfg_r, cfg_load,
    input  int_clr, int_en, comb_en,
    input  val_out, busy, cfg_err
  );

  modport slave (
    input  en, val_in, cfg_r, cfg_load,
    output int_clr, int_en, comb_en,
    output val_out, busy, cfg_err
  );

endinterface

// File: rtl/cic_decim_ctrl_cnt.sv
// Decimation phase counter, modulo the active ratio.
// wrap is registered: it is the comb strobe itself.
module cic_dec_cnt #(
  parameter int RW    = 8,
  parameter int R_DEF = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  input  logic          ld,
  input  logic [RW-1:0] r_new,
  output logic [RW-1:0] r_act,
  output logic          last,
  output logic          wrap
);

  logic [RW-1:0] dcnt;

  assign last = (dcnt == r_act - RW'(1));

  // phase count, ratio latch and registered wrap strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dcnt  <= '0;
      r_act <= RW'(R_DEF);
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr) begin
        dcnt <= '0;
      end else if (inc) begin
        if (last) begin
          dcnt <= '0;
          wrap <= 1'b1;
        end else begin
          dcnt <= dcnt + RW'(1);
        end
      end
      if (ld) r_act <= r_new;
    end
  end

endmodule

// File: rtl/cic_decim_ctrl.sv
// CIC decimator sequencer: strobes, fill masking
// and ratio changes at decimation boundaries.
module cic_decim_ctrl
  import cic_pkg::state_t, cic_pkg::IDLE,
         cic_pkg::FILL, cic_pkg::RUN,
         cic_pkg::R_MIN, cic_pkg::clog2;
#(
  parameter int RW    = 8,
  parameter int N_STG = cic_pkg::N_STG,
  parameter int R_DEF = cic_pkg::R_DEF
) (
  input  logic            clk,
  input  logic            rst,
  cic_decim_ctrl_if.slave bus
);

  localparam int FW = clog2(N_STG + 1);

  state_t        state, state_d;
  logic [FW-1:0] fcnt, fcnt_d;
  logic [RW-1:0] r_pend, r_act;
  logic          last, wrap;
  logic          inc, clr, ld, wrap_now;
  logic          int_clr, int_clr_d;
  logic          int_en, int_en_d;
  logic          vo_pend, vo_pend_d;
  logic          val_out, val_out_d;
  logic          busy, cfg_err;

  cic_dec_cnt #(
    .RW    (RW),
    .R_DEF (R_DEF)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .clr   (clr),
    .ld    (ld),
    .r_new (r_pend),
    .r_act (r_act),
    .last  (last),
    .wrap  (wrap)
  );

  // next state, fill count and strobe decode
  always_comb begin
    state_d   = state;
    fcnt_d    = fcnt;
    int_clr_d = 1'b0;
    int_en_d  = 1'b0;
    vo_pend_d = 1'b0;
    val_out_d = 1'b0;
    inc       = 1'b0;
    clr       = 1'b0;
    ld        = 1'b0;
    wrap_now  = bus.val_in & last;
    unique case (state)
      IDLE: begin
        if (bus.en) begin
          state_d   = FILL;
          fcnt_d    = '0;
          int_clr_d = 1'b1;
          clr       = 1'b1;
          ld        = 1'b1;
        end
      end
      FILL, RUN: begin
        if (!bus.en) begin
          state_d = IDLE;
          fcnt_d  = '0;
          clr     = 1'b1;
        end else begin
          int_en_d  = bus.val_in;
          inc       = bus.val_in;
          val_out_d = vo_pend;
          if (wrap_now) begin
            ld        = 1'b1;
            vo_pend_d = (state == RUN);
            if (r_pend != r_act) begin
              state_d = FILL;
              fcnt_d  = '0;
            end else if (state == FILL) begin
              if (fcnt != FW'(N_STG))
                fcnt_d = fcnt + 1'b1;
              if (fcnt == FW'(N_STG - 1))
                state_d = RUN;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        fcnt_d  = '0;
        clr     = 1'b1;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      fcnt    <= '0;
      int_clr <= 1'b0;
      int_en  <= 1'b0;
      vo_pend <= 1'b0;
      val_out <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      fcnt    <= fcnt_d;
      int_clr <= int_clr_d;
      int_en  <= int_en_d;
      vo_pend <= vo_pend_d;
      val_out <= val_out_d;
      busy    <= (state_d != IDLE);
    end
  end

  // pending ratio and sticky illegal-ratio flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend  <= RW'(R_DEF);
      cfg_err <= 1'b0;
    end else if (bus.cfg_load) begin
      if (bus.cfg_r >= RW'(R_MIN)) begin
        r_pend  <= bus.cfg_r;
        cfg_err <= 1'b0;
      end else begin
        cfg_err <= 1'b1;
      end
    end
  end

  assign bus.int_clr = int_clr;
  assign bus.int_en  = int_en;
  assign bus.comb_en = wrap;
  assign bus.val_out = val_out;
  assign bus.busy    = busy;
  assign bus.cfg_err = cfg_err;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl (R_DEF=16, N_STG=3).
// Outputs packed as {int_clr,int_en,comb_en,val_out,busy,cfg_err}.
module tb_cic_decim_ctrl;

  typedef struct {
    logic       en;
    logic       val;
    logic       ld;
    logic [7:0] r;
    logic [5:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;
  vec_t vq[$];

  cic_decim_ctrl_if #(.RW(8)) bus ();

  cic_decim_ctrl #(
    .RW    (8),
    .N_STG (3),
    .R_DEF (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {bus.int_clr, bus.int_en, bus.comb_en,
            bus.val_out, bus.busy, bus.cfg_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic val,
                       input logic ld, input logic [7:0] r);
    bus.en       = en;
    bus.val_in   = val;
    bus.cfg_load = ld;
    bus.cfg_r    = r;
  endtask

  task automatic chk(input string nm, input int act,
                     input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic val,
                     input logic ld, input logic [7:0] r,
                     input logic [5:0] e);
    vec_t v;
    v.en  = en;
    v.val = val;
    v.ld  = ld;
    v.r   = r;
    v.exp = e;
    vq.push_back(v);
  endtask

  initial begin
    int first;
    int nclr;
    int nval;
    int nie;
    int nce;
    int cnt;
    logic [5:0] e;
    nvec = 0;
    nerr = 0;
    rst  = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'd0);

    // R=4, continuous samples: fill then first val_out
    add(0, 0, 1, 8'd4, 6'b000000);
    add(1, 0, 0, 8'd0, 6'b100010);
    for (int k = 1; k <= 17; k++) begin
      e = 6'b010010;
      e[3] = (k % 4 == 0);
      e[2] = (k == 17);
      add(1, 1, 0, 8'd0, e);
    end
    // illegal ratio: flag set, R=4 kept in RUN
    add(1, 0, 1, 8'd1, 6'b000011);
    add(1, 1, 0, 8'd0, 6'b010011);
    add(1, 1, 0, 8'd0, 6'b010011);
    add(1, 1, 0, 8'd0, 6'b011011);
    add(1, 1, 0, 8'd0, 6'b010111);
    add(1, 0, 1, 8'd5, 6'b000010);
    // en drop with sample, then restart at R=5
    add(0, 1, 0, 8'd0, 6'b000000);
    add(0, 0, 0, 8'd0, 6'b000000);
    add(1, 0, 0, 8'd0, 6'b100010);
    for (int k = 1; k <= 21; k++) begin
      e = 6'b010010;
      e[3] = (k % 5 == 0);
      e[2] = (k == 21);
      add(1, 1, 0, 8'd0, e);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", outs(), 6'b000000);
    rst = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].en, vq[i].val, vq[i].ld, vq[i].r);
      tick();
      chk($sformatf("vec%0d", i), outs(), vq[i].exp);
    end

    // async reset mid-RUN clears everything
    drive(1'b1, 1'b1, 1'b1, 8'd0);
    tick();
    chk("err_before_rst", outs(), 6'b010011);
    drive(1'b1, 1'b1, 1'b0, 8'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst", outs(), 6'b000000);
    #2;
    rst = 1'b1;
    tick();
    chk("rst_restart", outs(), 6'b100010);
    first = 0;
    nclr  = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (bus.int_clr) nclr++;
      if (bus.comb_en && first == 0) first = n;
    end
    chk("rst_clr_once", nclr, 0);
    chk("rst_r16_first_comb", first, 16);

    // R=4, one sample every third cycle
    drive(1'b0, 1'b0, 1'b1, 8'd4);
    tick();
    chk("sparse_idle", outs(), 6'b000000);
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    tick();
    chk("sparse_start", outs(), 6'b100010);
    nval = 0;
    nie  = 0;
    nce  = 0;
    cnt  = 0;
    for (int i = 0; i < 60; i++) begin
      drive(1'b1, (i % 3 == 0), 1'b0, 8'd0);
      tick();
      if (i % 3 == 0) begin
        nval++;
        cnt++;
      end
      if (bus.int_en) nie++;
      if (bus.comb_en) nce++;
      chk($sformatf("sparse_ie%0d", i),
          bus.int_en, (i % 3 == 0));
      chk($sformatf("sparse_ce%0d", i), bus.comb_en,
          (i % 3 == 0) && (cnt % 4 == 0));
    end
    chk("sparse_ie_count", nie, nval);
    chk("sparse_ce_count", nce, 5);

    // ratio change 4->8 requested at dcnt=1 in RUN
    drive(1'b1, 1'b1, 1'b0, 8'd0);
    tick();
    chk("chg_pre", outs(), 6'b010010);
    drive(1'b1, 1'b0, 1'b1, 8'd8);
    tick();
    chk("chg_load", outs(), 6'b000010);
    for (int j = 1; j <= 37; j++) begin
      drive(1'b1, 1'b1, 1'b0, 8'd0);
      tick();
      e = 6'b010010;
      e[3] = (j == 3) || (j >= 11 && (j - 11) % 8 == 0);
      e[2] = (j == 4) || (j == 36);
      chk($sformatf("chg%0d", j), outs(), e);
    end

    drive(1'b0, 1'b0, 1'b0, 8'd0);
    tick();
    chk("final_idle", outs(), 6'b000000);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
